// File: rtl/dcpu_bus_pkg.sv
// Shared definitions for the dcpu two-master bus arbiter: arbiter states,
// strobe width, default widths and the round-robin pick used on every release.
package dcpu_bus_pkg;

    localparam int STB_W       = 2;
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 16;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GNT0 = 3'd1,
        GNT1 = 3'd2,
        ABT0 = 3'd3,
        ABT1 = 3'd4
    } arb_state_t;

    // A tie goes to whoever did not own the bus last; a releasing master has
    // req low, so the same pick also serves as the GNTx/ABTx exit rule.
    function automatic arb_state_t arbitrate(input logic [1:0] req, input logic last_owner);
        arb_state_t pick;
        pick = IDLE;
        if (req == 2'b11) begin
            pick = last_owner ? GNT0 : GNT1;
        end else if (req[0]) begin
            pick = GNT0;
        end else if (req[1]) begin
            pick = GNT1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/dcpu_bus_watchdog.sv
// Per-transfer ack watchdog: counts stalled strobe cycles and flags the cycle
// on which the TIMEOUT-th consecutive stall is seen. TIMEOUT=0 disables it.
module dcpu_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic run,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, srst, clr, run};
            assign expire        = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (srst || clr) begin
                    count_reg <= '0;
                end else if (run) begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            // run already excludes an ack, so an ack on the last cycle wins
            assign expire = run && (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// Two-master round-robin arbiter for the dcpu external bus. A grant is held for
// a whole cyc burst; a stalled transfer is aborted by the watchdog with an error pulse.
module dcpu_bus_arbiter
    import dcpu_bus_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_m0_cyc,
    input  logic [STB_W-1:0] i_m0_stb,
    input  logic             i_m0_we,
    input  logic [AW-1:0]    i_m0_addr,
    input  logic [DW-1:0]    i_m0_dat,
    output logic             o_m0_ack,
    output logic             o_m0_err,
    output logic [DW-1:0]    o_m0_dat,
    input  logic             i_m1_cyc,
    input  logic [STB_W-1:0] i_m1_stb,
    input  logic             i_m1_we,
    input  logic [AW-1:0]    i_m1_addr,
    input  logic [DW-1:0]    i_m1_dat,
    output logic             o_m1_ack,
    output logic             o_m1_err,
    output logic [DW-1:0]    o_m1_dat,
    output logic             o_cyc,
    output logic [STB_W-1:0] o_stb,
    output logic             o_we,
    output logic [AW-1:0]    o_addr,
    output logic [DW-1:0]    o_dat,
    input  logic             i_ack,
    input  logic [DW-1:0]    i_dat,
    output logic [1:0]       o_grant
);

    arb_state_t state_reg, state_next;
    logic       last_owner_reg, last_owner_next;
    logic       in_gnt, in_abt, owner;
    logic       stb_active, wd_run, wd_clr, wd_expire;
    logic [1:0] req, ack_vec, err_vec;

    assign req    = {i_m1_cyc, i_m0_cyc};
    assign in_gnt = (state_reg == GNT0) || (state_reg == GNT1);
    assign in_abt = (state_reg == ABT0) || (state_reg == ABT1);
    assign owner  = (state_reg == GNT1) || (state_reg == ABT1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        unique case (state_reg)
            IDLE: state_next = arbitrate(req, last_owner_reg);
            GNT0, GNT1: begin
                last_owner_next = owner;
                if (wd_expire) begin
                    state_next = owner ? ABT1 : ABT0;
                end else if (!req[owner]) begin
                    state_next = arbitrate(req, owner);
                end
            end
            ABT0, ABT1: begin
                if (!req[owner]) begin
                    state_next = arbitrate(req, owner);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slave side is a plain combinational mux of the owner; silent in IDLE/ABTx and during reset.
    always_comb begin
        o_cyc  = 1'b0;
        o_stb  = '0;
        o_we   = 1'b0;
        o_addr = '0;
        o_dat  = '0;
        if (in_gnt && !i_reset) begin
            if (owner) begin
                o_cyc  = i_m1_cyc;
                o_stb  = i_m1_stb;
                o_we   = i_m1_we;
                o_addr = i_m1_addr;
                o_dat  = i_m1_dat;
            end else begin
                o_cyc  = i_m0_cyc;
                o_stb  = i_m0_stb;
                o_we   = i_m0_we;
                o_addr = i_m0_addr;
                o_dat  = i_m0_dat;
            end
        end
    end

    assign stb_active = |o_stb;
    assign wd_run     = in_gnt && stb_active && !i_ack;
    assign wd_clr     = !wd_run || (state_next != state_reg);

    dcpu_bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (i_clk),
        .srst  (i_reset),
        .clr   (wd_clr),
        .run   (wd_run),
        .expire(wd_expire)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign ack_vec[gi] = in_gnt && (owner == 1'(gi)) && i_ack && stb_active;
            assign err_vec[gi] = wd_expire && (owner == 1'(gi));
        end
    endgenerate

    assign o_m0_ack = ack_vec[0];
    assign o_m1_ack = ack_vec[1];
    assign o_m0_err = err_vec[0];
    assign o_m1_err = err_vec[1];
    assign o_m0_dat = i_dat;
    assign o_m1_dat = i_dat;

    // An aborted owner still holds the bus, so it stays visible in the status.
    assign o_grant = i_reset ? 2'b00 : {(in_gnt || in_abt) && owner, (in_gnt || in_abt) && !owner};

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Bench for dcpu_bus_arbiter (TIMEOUT=4): hand-derived cycle table for the
// corner cases, then random traffic compared against an ownership-level model.
module tb_dcpu_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m_cyc  [2];
    logic [1:0]    m_stb  [2];
    logic          m_we   [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdat [2];
    logic          ack;
    logic [DW-1:0] rdat;

    logic          o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic [DW-1:0] o_m0_dat, o_m1_dat, o_dat;
    logic          o_cyc, o_we;
    logic [1:0]    o_stb, o_grant;
    logic [AW-1:0] o_addr;

    dcpu_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
        .i_m0_addr(m_addr[0]), .i_m0_dat(m_wdat[0]),
        .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_dat(o_m0_dat),
        .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
        .i_m1_addr(m_addr[1]), .i_m1_dat(m_wdat[1]),
        .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_dat(o_m1_dat),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_dat(o_dat),
        .i_ack(ack), .i_dat(rdat), .o_grant(o_grant)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // Ownership-level model: who holds the bus, whether that burst was aborted,
    // who held it last, and how many consecutive stalled strobe cycles have passed.
    int  mdl_owner;
    bit  mdl_abort;
    int  mdl_last;
    int  mdl_stalls;

    logic          e_cyc, e_we;
    logic [1:0]    e_stb, e_grant, e_ack, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dat;

    function automatic int pick(input int last);
        if (m_cyc[0] && m_cyc[1]) return 1 - last;
        if (m_cyc[0]) return 0;
        if (m_cyc[1]) return 1;
        return -1;
    endfunction

    task automatic model_expect();
        e_cyc = 0; e_stb = 0; e_we = 0; e_addr = 0; e_dat = 0;
        e_grant = 0; e_ack = 0; e_err = 0;
        if (!rst && mdl_owner >= 0) begin
            e_grant = (mdl_owner == 0) ? 2'b01 : 2'b10;
            if (!mdl_abort) begin
                e_cyc  = m_cyc[mdl_owner];
                e_stb  = m_stb[mdl_owner];
                e_we   = m_we[mdl_owner];
                e_addr = m_addr[mdl_owner];
                e_dat  = m_wdat[mdl_owner];
                if (e_stb != 0) begin
                    if (ack) e_ack[mdl_owner] = 1'b1;
                    else if (mdl_stalls == TO - 1) e_err[mdl_owner] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            mdl_owner = -1; mdl_abort = 0; mdl_last = 1; mdl_stalls = 0;
        end else if (mdl_owner < 0) begin
            mdl_owner = pick(mdl_last);
        end else if (mdl_abort) begin
            if (!m_cyc[mdl_owner]) begin
                mdl_owner = pick(mdl_owner); mdl_abort = 0; mdl_stalls = 0;
            end
        end else begin
            mdl_last = mdl_owner;
            if (e_err != 0) begin
                mdl_abort = 1; mdl_stalls = 0;
            end else if (!m_cyc[mdl_owner]) begin
                mdl_owner = pick(mdl_last); mdl_stalls = 0;
            end else if (m_stb[mdl_owner] != 0 && !ack) begin
                mdl_stalls++;
            end else begin
                mdl_stalls = 0;
            end
        end
    endtask

    typedef struct {
        bit rst, c0; bit [1:0] s0; bit c1; bit [1:0] s1; bit ak;
        bit cy; bit [1:0] st; bit [7:0] ad; bit [1:0] gr; bit a0, a1, e0, e1;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit c0, input bit [1:0] s0, input bit c1,
                                input bit [1:0] s1, input bit ak, input bit cy, input bit [1:0] st,
                                input bit [7:0] ad, input bit [1:0] gr,
                                input bit a0, input bit a1, input bit e0, input bit e1);
        vec_t v;
        v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ak = ak;
        v.cy = cy; v.st = st; v.ad = ad; v.gr = gr; v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t v;
        int   n_ack, n_err, ack_div;

        // rst c0 s0 c1 s1 ack | cyc stb addr grant a0 a1 e0 e1
        // single m0 transfer, ack two cycles after the request
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 1,3,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,1, 1,3,8'h10,1, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        // tie after reset -> m0, gapless handover to m1, round-robin tie -> m1
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,1, 1,3,8'h10,1, 1,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,0, 0,0,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,1, 1,1,8'h20,2, 0,1,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 0,0,8'h20,2, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,1, 1,3,8'h10,1, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,0, 1,1,8'h20,2, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h20,2, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        // m0 burst of three transfers while m1 waits
        tbl.push_back(mk(0,1,3,1,1,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,1, 1,3,8'h10,1, 1,0,0,0));
        tbl.push_back(mk(0,1,0,1,1,0, 1,0,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,1, 1,3,8'h10,1, 1,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,0, 1,3,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,1, 1,3,8'h10,1, 1,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,0, 0,0,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,0, 1,1,8'h20,2, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h20,2, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        // watchdog: error on 4th stall, abort holds until cyc drops, late ack dropped
        tbl.push_back(mk(0,1,3,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 1,3,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 1,3,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 1,3,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 1,3,8'h10,1, 0,0,1,0));
        tbl.push_back(mk(0,1,3,0,0,1, 0,0,8'h00,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 0,0,8'h00,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h00,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        // ack on the expiry cycle wins
        tbl.push_back(mk(0,1,3,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 1,3,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 1,3,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0, 1,3,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,1, 1,3,8'h10,1, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h00,0, 0,0,0,0));
        // reset in the middle of a GNT1 transfer
        tbl.push_back(mk(0,0,0,1,1,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,0, 1,1,8'h20,2, 0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,1, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,0, 0,0,8'h00,0, 0,0,0,0));
        tbl.push_back(mk(0,1,3,1,1,1, 1,3,8'h10,1, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h10,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,8'h00,0, 0,0,0,0));

        rst = 1'b1; ack = 1'b0; rdat = 16'h5a5a;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 2'b00; m_we[i] = 1'(i);
            m_wdat[i] = 16'(16'h1234 + i);
        end
        m_addr[0] = 32'h10; m_addr[1] = 32'h20;
        mdl_owner = -1; mdl_abort = 0; mdl_last = 1; mdl_stalls = 0;
        @(posedge clk); @(posedge clk); #1;

        foreach (tbl[i]) begin
            v = tbl[i];
            rst = v.rst; ack = v.ak;
            m_cyc[0] = v.c0; m_stb[0] = v.s0; m_cyc[1] = v.c1; m_stb[1] = v.s1;
            @(negedge clk);
            model_expect();
            chk("tbl_cyc",   i, 64'(o_cyc),    64'(v.cy));
            chk("tbl_stb",   i, 64'(o_stb),    64'(v.st));
            chk("tbl_addr",  i, 64'(o_addr),   64'(v.ad));
            chk("tbl_grant", i, 64'(o_grant),  64'(v.gr));
            chk("tbl_m0ack", i, 64'(o_m0_ack), 64'(v.a0));
            chk("tbl_m1ack", i, 64'(o_m1_ack), 64'(v.a1));
            chk("tbl_m0err", i, 64'(o_m0_err), 64'(v.e0));
            chk("tbl_m1err", i, 64'(o_m1_err), 64'(v.e1));
            $display("vec %0d: rst=%0b req=%0b%0b ack=%0b -> cyc=%0b grant=%02b ack=%0b%0b err=%0b%0b",
                     i, rst, m_cyc[1], m_cyc[0], ack, o_cyc, o_grant, o_m1_ack, o_m0_ack,
                     o_m1_err, o_m0_err);
            @(posedge clk);
            model_update();
            #1;
        end

        // Random traffic against the model, starting from a clean reset.
        rst = 1'b1; m_cyc[0] = 0; m_cyc[1] = 0; m_stb[0] = 0; m_stb[1] = 0; ack = 0;
        @(negedge clk); model_expect();
        @(posedge clk); model_update(); #1;
        n_ack = 0; n_err = 0;
        for (int cyc_i = 0; cyc_i < 1500; cyc_i++) begin
            ack_div = ((cyc_i / 100) % 2 == 1) ? 1 : 6;
            rst  = ($urandom_range(0, 249) == 0);
            ack  = ($urandom_range(0, ack_div) == 0);
            rdat = 16'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        m_cyc[i] = 1'b0; m_stb[i] = 2'b00;
                    end else begin
                        m_stb[i] = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    m_cyc[i] = 1'b1; m_stb[i] = 2'($urandom_range(1, 3));
                end
                m_we[i]   = 1'($urandom_range(0, 1));
                m_addr[i] = $urandom;
                m_wdat[i] = 16'($urandom);
            end
            @(negedge clk);
            model_expect();
            chk("rnd_cyc",   cyc_i, 64'(o_cyc),    64'(e_cyc));
            chk("rnd_stb",   cyc_i, 64'(o_stb),    64'(e_stb));
            chk("rnd_we",    cyc_i, 64'(o_we),     64'(e_we));
            chk("rnd_addr",  cyc_i, 64'(o_addr),   64'(e_addr));
            chk("rnd_wdat",  cyc_i, 64'(o_dat),    64'(e_dat));
            chk("rnd_grant", cyc_i, 64'(o_grant),  64'(e_grant));
            chk("rnd_m0ack", cyc_i, 64'(o_m0_ack), 64'(e_ack[0]));
            chk("rnd_m1ack", cyc_i, 64'(o_m1_ack), 64'(e_ack[1]));
            chk("rnd_m0err", cyc_i, 64'(o_m0_err), 64'(e_err[0]));
            chk("rnd_m1err", cyc_i, 64'(o_m1_err), 64'(e_err[1]));
            chk("rnd_m0dat", cyc_i, 64'(o_m0_dat), 64'(rdat));
            chk("rnd_m1dat", cyc_i, 64'(o_m1_dat), 64'(rdat));
            if (e_ack != 0 || e_err != 0) begin
                if (e_ack != 0) n_ack++;
                if (e_err != 0) n_err++;
                $display("txn %0d: master %0d %s addr=%08h", cyc_i, mdl_owner,
                         (e_ack != 0) ? "ack" : "abort", e_addr);
            end
            @(posedge clk);
            model_update();
            #1;
        end
        $display("random phase: %0d acks, %0d aborts", n_ack, n_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
